// File: rtl/pipeline_stall_controller_if.sv
// Multiply/divide handshake between the stall controller (initiator)
// and the multicycle mult/div unit.
interface pipeline_stall_controller_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        md_result_ready;
  logic [31:0] md_result_in;
  logic        md_exception_in;

  modport master (
    output ctrl_MULT,
    output ctrl_DIV,
    input  md_result_ready,
    input  md_result_in,
    input  md_exception_in
  );

  modport slave (
    input  ctrl_MULT,
    input  ctrl_DIV,
    output md_result_ready,
    output md_result_in,
    output md_exception_in
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller for the 5-stage core: drives latch enables and
// bubble selects, launches mult/div operations and freezes the front end
// until the result (or a timeout) comes back.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | normal flow; hazard stalls and branch flushes handled here
// BUSY  | mult/div in flight; front end frozen, XM fed bubbles
// DONE  | result registered; md instruction advances into XM with it
module pipeline_stall_controller #(
  parameter int MD_TIMEOUT  = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  pipeline_stall_controller_if.master md,
  input  logic [31:0]                DX_Latch_Instr,
  input  logic                       load_use_stall,
  input  logic                       branch_taken,
  output logic                       PC_enable,
  output logic                       FD_enable,
  output logic                       DX_enable,
  output logic                       XM_enable,
  output logic                       WB_enable,
  output logic                       FD_flush,
  output logic                       DX_bubble,
  output logic                       XM_bubble,
  output logic                       md_result_valid,
  output logic [31:0]                md_result_out,
  output logic                       md_error_out,
  output logic                       md_busy,
  output logic [STALL_CNT_W-1:0]     stall_cycles
);

  localparam int CYC_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MD_TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [CYC_W-1:0] cyc_cnt;

  logic [4:0] opcode;
  logic [4:0] alu_op;
  logic       is_mult;
  logic       is_div;
  logic       dx_is_md;

  // Combinational control before reset gating.
  logic pc_en_c, fd_en_c, dx_en_c, xm_en_c, wb_en_c;
  logic fd_flush_c, dx_bubble_c, xm_bubble_c;
  logic ctrl_mult_c, ctrl_div_c, result_valid_c;
  logic cyc_clr, cap_ready, cap_timeout;

  // Only the opcode and ALU-op fields are decoded here.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, DX_Latch_Instr[26:7], DX_Latch_Instr[1:0]};

  assign opcode   = DX_Latch_Instr[31:27];
  assign alu_op   = DX_Latch_Instr[6:2];
  assign is_mult  = (opcode == 5'b00000) && (alu_op == 5'b00110);
  assign is_div   = (opcode == 5'b00000) && (alu_op == 5'b00111);
  assign dx_is_md = is_mult || is_div;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus latch enables, bubbles and start pulses.
  always_comb begin
    next_state     = state;
    pc_en_c        = 1'b0;
    fd_en_c        = 1'b0;
    dx_en_c        = 1'b0;
    xm_en_c        = 1'b0;
    wb_en_c        = 1'b0;
    fd_flush_c     = 1'b0;
    dx_bubble_c    = 1'b0;
    xm_bubble_c    = 1'b0;
    ctrl_mult_c    = 1'b0;
    ctrl_div_c     = 1'b0;
    result_valid_c = 1'b0;
    cyc_clr        = 1'b0;
    cap_ready      = 1'b0;
    cap_timeout    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (dx_is_md) begin
          // Launch: md instruction stays in DX, XM gets a bubble.
          ctrl_mult_c = is_mult;
          ctrl_div_c  = is_div;
          xm_en_c     = 1'b1;
          xm_bubble_c = 1'b1;
          wb_en_c     = 1'b1;
          cyc_clr     = 1'b1;
          next_state  = ST_BUSY;
        end else if (branch_taken) begin
          pc_en_c     = 1'b1;
          fd_en_c     = 1'b1;
          dx_en_c     = 1'b1;
          xm_en_c     = 1'b1;
          wb_en_c     = 1'b1;
          fd_flush_c  = 1'b1;
          dx_bubble_c = 1'b1;
        end else if (load_use_stall) begin
          dx_en_c     = 1'b1;
          xm_en_c     = 1'b1;
          wb_en_c     = 1'b1;
          dx_bubble_c = 1'b1;
        end else begin
          pc_en_c = 1'b1;
          fd_en_c = 1'b1;
          dx_en_c = 1'b1;
          xm_en_c = 1'b1;
          wb_en_c = 1'b1;
        end
      end

      ST_BUSY: begin
        xm_en_c     = 1'b1;
        wb_en_c     = 1'b1;
        xm_bubble_c = 1'b1;
        // A ready pulse on the timeout cycle still delivers its result.
        if (md.md_result_ready) begin
          cap_ready  = 1'b1;
          next_state = ST_DONE;
        end else if (cyc_cnt == CYC_LAST) begin
          cap_timeout = 1'b1;
          next_state  = ST_DONE;
        end
      end

      ST_DONE: begin
        // DX still holds the md instruction here, so no restart check.
        pc_en_c        = 1'b1;
        fd_en_c        = 1'b1;
        dx_en_c        = 1'b1;
        xm_en_c        = 1'b1;
        wb_en_c        = 1'b1;
        result_valid_c = 1'b1;
        next_state     = ST_IDLE;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Cycles spent in BUSY, used for the timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
    end else if (cyc_clr) begin
      cyc_cnt <= '0;
    end else if (state == ST_BUSY) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // Result/error capture for the XM latch; held until the next completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_result_out <= '0;
      md_error_out  <= 1'b0;
    end else if (cap_ready) begin
      md_result_out <= md.md_result_in;
      md_error_out  <= md.md_exception_in;
    end else if (cap_timeout) begin
      md_result_out <= '0;
      md_error_out  <= 1'b1;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (!pc_en_c && (stall_cycles != STALL_MAX)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // Everything combinational is forced low while reset is held.
  assign PC_enable       = reset_n & pc_en_c;
  assign FD_enable       = reset_n & fd_en_c;
  assign DX_enable       = reset_n & dx_en_c;
  assign XM_enable       = reset_n & xm_en_c;
  assign WB_enable       = reset_n & wb_en_c;
  assign FD_flush        = reset_n & fd_flush_c;
  assign DX_bubble       = reset_n & dx_bubble_c;
  assign XM_bubble       = reset_n & xm_bubble_c;
  assign md.ctrl_MULT    = reset_n & ctrl_mult_c;
  assign md.ctrl_DIV     = reset_n & ctrl_div_c;
  assign md_result_valid = reset_n & result_valid_c;
  assign md_busy         = reset_n & (state != ST_IDLE);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a per-cycle vector table
// followed by hand-written reset and timeout-race sequences.
module tb_pipeline_stall_controller;

  localparam int MD_TIMEOUT  = 8;
  localparam int STALL_CNT_W = 4;

  localparam logic [31:0] I_ADD  = 32'h0000_0000;
  localparam logic [31:0] I_MULT = 32'h0000_0018;
  localparam logic [31:0] I_DIV  = 32'h0000_001C;
  localparam logic [31:0] I_OP1  = 32'h0800_0018;

  logic                   clock;
  logic                   reset_n;
  logic [31:0]            DX_Latch_Instr;
  logic                   load_use_stall;
  logic                   branch_taken;
  logic                   PC_enable, FD_enable, DX_enable, XM_enable, WB_enable;
  logic                   FD_flush, DX_bubble, XM_bubble;
  logic                   md_result_valid;
  logic [31:0]            md_result_out;
  logic                   md_error_out;
  logic                   md_busy;
  logic [STALL_CNT_W-1:0] stall_cycles;

  pipeline_stall_controller_if md_if ();

  pipeline_stall_controller #(
    .MD_TIMEOUT  (MD_TIMEOUT),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .md              (md_if.master),
    .DX_Latch_Instr  (DX_Latch_Instr),
    .load_use_stall  (load_use_stall),
    .branch_taken    (branch_taken),
    .PC_enable       (PC_enable),
    .FD_enable       (FD_enable),
    .DX_enable       (DX_enable),
    .XM_enable       (XM_enable),
    .WB_enable       (WB_enable),
    .FD_flush        (FD_flush),
    .DX_bubble       (DX_bubble),
    .XM_bubble       (XM_bubble),
    .md_result_valid (md_result_valid),
    .md_result_out   (md_result_out),
    .md_error_out    (md_error_out),
    .md_busy         (md_busy),
    .stall_cycles    (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]            instr;
    logic                   lus;
    logic                   br;
    logic                   rdy;
    logic [31:0]            res;
    logic                   exc;
    logic [4:0]             en;
    logic [2:0]             bub;
    logic [1:0]             ctl;
    logic                   valid;
    logic                   busy;
    logic [STALL_CNT_W-1:0] stall;
    logic [31:0]            res_out;
    logic                   err;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic [31:0] instr, input logic lus, input logic br, input logic rdy,
    input logic [31:0] res, input logic exc, input logic [4:0] en, input logic [2:0] bub,
    input logic [1:0] ctl, input logic valid, input logic busy,
    input logic [STALL_CNT_W-1:0] stall, input logic [31:0] res_out, input logic err);
    vec_t v;
    v.instr = instr; v.lus = lus; v.br = br; v.rdy = rdy; v.res = res; v.exc = exc;
    v.en = en; v.bub = bub; v.ctl = ctl; v.valid = valid; v.busy = busy;
    v.stall = stall; v.res_out = res_out; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {PC_enable, FD_enable, DX_enable, XM_enable, WB_enable};
  endfunction

  function automatic logic [2:0] bub_vec();
    return {FD_flush, DX_bubble, XM_bubble};
  endfunction

  function automatic logic [1:0] ctl_vec();
    return {md_if.ctrl_MULT, md_if.ctrl_DIV};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic lus, input logic br,
                       input logic rdy, input logic [31:0] res, input logic exc);
    DX_Latch_Instr            = instr;
    load_use_stall            = lus;
    branch_taken              = br;
    md_if.md_result_ready     = rdy;
    md_if.md_result_in        = res;
    md_if.md_exception_in     = exc;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, "_en"},    32'(en_vec()),         32'(v.en));
    chk({tag, "_bub"},   32'(bub_vec()),        32'(v.bub));
    chk({tag, "_ctl"},   32'(ctl_vec()),        32'(v.ctl));
    chk({tag, "_valid"}, 32'(md_result_valid),  32'(v.valid));
    chk({tag, "_busy"},  32'(md_busy),          32'(v.busy));
    chk({tag, "_stall"}, 32'(stall_cycles),     32'(v.stall));
    chk({tag, "_res"},   md_result_out,         v.res_out);
    chk({tag, "_err"},   32'(md_error_out),     32'(v.err));
  endtask

  initial begin
    vec_t v;

    //            instr  lus br rdy res           exc  en        bub     ctl    vl bs stall res_out       err
    vecs[0]  = mk(I_ADD,  0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 0, 0, 4'd0,  32'h0,        0);
    vecs[1]  = mk(I_ADD,  1, 0, 0, 32'h0,        0, 5'b00111, 3'b010, 2'b00, 0, 0, 4'd0,  32'h0,        0);
    vecs[2]  = mk(I_ADD,  1, 1, 0, 32'h0,        0, 5'b11111, 3'b110, 2'b00, 0, 0, 4'd1,  32'h0,        0);
    vecs[3]  = mk(I_ADD,  0, 0, 1, 32'h55,       1, 5'b11111, 3'b000, 2'b00, 0, 0, 4'd1,  32'h0,        0);
    vecs[4]  = mk(I_OP1,  0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 0, 0, 4'd1,  32'h0,        0);
    vecs[5]  = mk(I_MULT, 0, 0, 0, 32'h0,        0, 5'b00011, 3'b001, 2'b10, 0, 0, 4'd1,  32'h0,        0);
    vecs[6]  = mk(I_MULT, 1, 1, 0, 32'h0,        0, 5'b00011, 3'b001, 2'b00, 0, 1, 4'd2,  32'h0,        0);
    vecs[7]  = mk(I_MULT, 0, 0, 0, 32'h0,        0, 5'b00011, 3'b001, 2'b00, 0, 1, 4'd3,  32'h0,        0);
    vecs[8]  = mk(I_MULT, 0, 0, 1, 32'h42,       0, 5'b00011, 3'b001, 2'b00, 0, 1, 4'd4,  32'h0,        0);
    vecs[9]  = mk(I_MULT, 0, 0, 1, 32'h99,       1, 5'b11111, 3'b000, 2'b00, 1, 1, 4'd5,  32'h42,       0);
    vecs[10] = mk(I_ADD,  0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 0, 0, 4'd5,  32'h42,       0);
    vecs[11] = mk(I_DIV,  0, 0, 0, 32'h0,        0, 5'b00011, 3'b001, 2'b01, 0, 0, 4'd5,  32'h42,       0);
    vecs[12] = mk(I_DIV,  0, 0, 1, 32'hDEAD,     1, 5'b00011, 3'b001, 2'b00, 0, 1, 4'd6,  32'h42,       0);
    vecs[13] = mk(I_DIV,  0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 1, 1, 4'd7,  32'hDEAD,     1);
    vecs[14] = mk(I_ADD,  0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 0, 0, 4'd7,  32'hDEAD,     1);
    vecs[15] = mk(I_MULT, 0, 0, 0, 32'h0,        0, 5'b00011, 3'b001, 2'b10, 0, 0, 4'd7,  32'hDEAD,     1);
    vecs[16] = mk(I_MULT, 0, 0, 1, 32'h7,        0, 5'b00011, 3'b001, 2'b00, 0, 1, 4'd8,  32'hDEAD,     1);
    vecs[17] = mk(I_MULT, 0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 1, 1, 4'd9,  32'h7,        0);
    vecs[18] = mk(I_ADD,  0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 0, 0, 4'd9,  32'h7,        0);
    vecs[19] = mk(I_MULT, 0, 0, 0, 32'h0,        0, 5'b00011, 3'b001, 2'b10, 0, 0, 4'd9,  32'h7,        0);
    for (int i = 0; i < 8; i++) begin
      // BUSY cycles 0..7 of a timeout run; counter saturates at 15.
      vecs[20+i] = mk(I_MULT, 0, 0, 0, 32'h0, 0, 5'b00011, 3'b001, 2'b00, 0, 1,
                      (i >= 5) ? 4'd15 : 4'(10 + i), 32'h7, 0);
    end
    vecs[28] = mk(I_MULT, 0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 1, 1, 4'd15, 32'h0,        1);
    vecs[29] = mk(I_ADD,  1, 0, 0, 32'h0,        0, 5'b00111, 3'b010, 2'b00, 0, 0, 4'd15, 32'h0,        1);
    vecs[30] = mk(I_ADD,  0, 0, 0, 32'h0,        0, 5'b11111, 3'b000, 2'b00, 0, 0, 4'd15, 32'h0,        1);

    // Reset held with a mult in DX: nothing may fire.
    reset_n = 1'b0;
    drive(I_MULT, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    @(posedge clock);
    #1;
    v = mk(I_MULT, 0, 0, 0, 32'h0, 0, 5'b00000, 3'b000, 2'b00, 0, 0, 4'd0, 32'h0, 0);
    chk_all("rst", v);

    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].instr, vecs[i].lus, vecs[i].br, vecs[i].rdy, vecs[i].res, vecs[i].exc);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i]);
      @(negedge clock);
    end

    // Ready arriving on the timeout cycle must win over the timeout.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    drive(I_MULT, 0, 0, 0, 32'h0, 0);
    #1;
    chk("race_start_ctl", 32'(ctl_vec()), 32'(2'b10));
    for (int i = 0; i < MD_TIMEOUT; i++) begin
      @(negedge clock);
      if (i == MD_TIMEOUT - 1) drive(I_MULT, 0, 0, 1, 32'h1234, 0);
      else                     drive(I_MULT, 0, 0, 0, 32'h0, 0);
      #1;
      chk($sformatf("race_busy%0d", i), 32'(md_busy), 32'd1);
    end
    @(negedge clock);
    drive(I_MULT, 0, 0, 0, 32'h0, 0);
    #1;
    chk("race_valid", 32'(md_result_valid), 32'd1);
    chk("race_res",   md_result_out,        32'h1234);
    chk("race_err",   32'(md_error_out),    32'd0);
    chk("race_stall", 32'(stall_cycles),    32'd9);

    // Asynchronous reset in the middle of a BUSY run.
    @(negedge clock);
    drive(I_ADD, 0, 0, 0, 32'h0, 0);
    @(negedge clock);
    drive(I_MULT, 0, 0, 0, 32'h0, 0);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("mid_busy", 32'(md_busy), 32'd1);
    chk("mid_stall", 32'(stall_cycles), 32'd11);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_en",    32'(en_vec()),  32'd0);
    chk("arst_bub",   32'(bub_vec()), 32'd0);
    chk("arst_ctl",   32'(ctl_vec()), 32'd0);
    chk("arst_busy",  32'(md_busy),   32'd0);
    chk("arst_stall", 32'(stall_cycles), 32'd0);
    chk("arst_res",   md_result_out,  32'h0);
    @(negedge clock);
    drive(I_ADD, 0, 0, 0, 32'h0, 0);
    reset_n = 1'b1;
    #1;
    chk("post_en",   32'(en_vec()),  32'(5'b11111));
    chk("post_busy", 32'(md_busy),   32'd0);
    @(negedge clock);
    #1;
    chk("post_en2",   32'(en_vec()),  32'(5'b11111));
    chk("post_ctl",   32'(ctl_vec()), 32'd0);
    chk("post_stall", 32'(stall_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Sequential pipeline-control block that consumes the hazard unit's stall request, the execute-stage branch decision and the multiplier/divider handshake, and drives every pipeline-latch enable and bubble-insert select in the 5-stage core. It is the initiator of the `mult`/`div` handshake, and it holds the front end while the multicycle unit runs. It captures the unit's result and error for the XM latch, and keeps a saturating count of stall cycles.

## Interface
- `MD_TIMEOUT`, 64: maximum BUSY cycles before a forced abort.
- `STALL_CNT_W`, 16: width of the stall counter.
- `clock`  in  1  single core clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `DX_Latch_Instr`  in  32  instruction in DX. Opcode = [31:27]; ALU op = [6:2].
- `load_use_stall`  in  1  load-use stall request from the hazard detection unit.
- `branch_taken`  in  1  taken branch or jump resolved in X this cycle.
- `md_result_ready`  in  1  multdiv result valid, one-cycle pulse.
- `md_result_in`  in  32  multdiv result.
- `md_exception_in`  in  1  multdiv exception, qualified by `md_result_ready`.
- `PC_enable`, `FD_enable`, `DX_enable`, `XM_enable`, `WB_enable`  out  1 each  latch write enables.
- `FD_flush`  out  1  FD loads nop.
- `DX_bubble`  out  1  DX loads nop.
- `XM_bubble`  out  1  XM loads nop.
- `ctrl_MULT`, `ctrl_DIV`  out  1 each  one-cycle start pulses to multdiv.
- `md_result_valid`  out  1  XM takes `md_result_out` instead of the ALU output.
- `md_result_out`  out  32  registered result.
- `md_error_out`  out  1  registered exception or timeout.
- `md_busy`  out  1  state is not IDLE.
- `stall_cycles`  out  STALL_CNT_W  saturating count of cycles with `PC_enable`=0.

## Operation
- `DX_is_md` = opcode 00000 and ALU op 00110 (mult) or 00111 (div).
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE, priority order:**
  1. `DX_is_md` (start):
     - assert `ctrl_MULT` or `ctrl_DIV` for this cycle only;
     - PC, FD and DX enables = 0;
     - XM_enable = 1 with `XM_bubble` = 1; WB_enable = 1;
     - next state BUSY; clear `cyc_cnt`.
  2. `branch_taken`: all enables 1, `FD_flush` = 1, `DX_bubble` = 1.
  3. `load_use_stall`: PC and FD enables = 0; DX, XM and WB enables = 1; `DX_bubble` = 1.
  4. Otherwise: all enables 1; no bubbles.
- **BUSY:**
  - Outputs: PC, FD and DX enables = 0; XM and WB enables = 1; `XM_bubble` = 1.
  - `branch_taken` and `load_use_stall` are ignored.
  - `cyc_cnt` increments each cycle.
  - On `md_result_ready`: capture `md_result_in` into `md_result_out` and `md_exception_in` into `md_error_out`; next state DONE.
  - Else if `cyc_cnt` == `MD_TIMEOUT`-1: set `md_result_out` = 0 and `md_error_out` = 1; next state DONE.
- **DONE:**
  - Outputs: all enables 1; `md_result_valid` = 1; no bubbles.
  - The mult/div instruction advances to XM carrying the registered result.
  - Next state IDLE unconditionally. DONE never re-triggers a start, because DX still holds the old instruction during this cycle.
- **`stall_cycles`:** increments every cycle where `PC_enable` = 0; saturates at all-ones.
- **While `reset_n` = 0:**
  - all enables, bubbles, `ctrl_*`, `md_result_valid`, `md_busy` and `md_error_out` are 0;
  - `md_result_out` = 0 and `stall_cycles` = 0.

## Timing
- Enable, bubble and `ctrl_*` outputs are combinational from state plus current inputs. Registers update on the rising edge of `clock`.
- For a start at edge T0 (IDLE, pulse):
  - BUSY runs from T1.
  - `md_result_ready` seen in cycle Tk puts DONE at Tk+1.
  - The mult/div instruction enters XM at the end of Tk+1.
  - Total front-end freeze = k+1 cycles.
- Timeout with no ready: DONE in cycle T0+`MD_TIMEOUT`+1.
- `md_result_ready` in the IDLE or DONE state is ignored.
- A ready pulse arriving in the same cycle as the timeout wins: the captured result is used.
- Async reset mid-BUSY returns to IDLE immediately. No `ctrl_*` pulse is reissued until a new IDLE detection.

## Test plan
- **Load-use:** `load_use_stall`=1 for 1 cycle in IDLE -> PC_enable=0, FD_enable=0, DX_bubble=1 that cycle; `stall_cycles` 0->1.
- **Branch:** `branch_taken`=1 together with `load_use_stall`=1 -> FD_flush=1, DX_bubble=1, PC_enable=1; `stall_cycles` unchanged.
- **Mult:** DX=`mult` (ALU op 00110), ready with 32'h0000_0042 three cycles after start ->
  - one `ctrl_MULT` pulse;
  - 4 frozen cycles;
  - DONE cycle shows `md_result_valid`=1 and `md_result_out`=32'h42;
  - `stall_cycles`=4.
- **Div error:** DX=`div`, ready with `md_exception_in`=1 -> `md_error_out`=1 in DONE; `ctrl_DIV` pulses once; `ctrl_MULT` stays 0.
- **Timeout:** `MD_TIMEOUT`=8, ready never arrives -> DONE at start+9 with `md_error_out`=1 and `md_result_out`=0; back to IDLE next cycle.
- **Reset mid-BUSY:** drop `reset_n` in BUSY cycle 2 -> all enables 0 and `stall_cycles`=0 immediately; after release, state is IDLE and DX=`add` gives all enables 1.
